// File: rtl/switch_pkg.sv
// Shared switch definitions: word width and destination port codes.
// Used by the ingress queue and the downstream scheduler.
// No logic; types and constants only.
package switch_pkg;

    // Width of one packet word across the switch datapath
    localparam int WORD_W = 32;

    // Destination port code carried in bits [1:0] of every packet word
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PORT1 = 2'b01,
        PORT2 = 2'b10,
        PORT3 = 2'b11
    } port_e;

endpackage

// File: rtl/queue_ram.sv
// Storage array for the ingress queue: DEPTH x WIDTH, one write port.
// Latency: write lands on the clock edge, read is combinational.
// No backpressure; the caller guards writes.
module queue_ram
    import switch_pkg::*;
#(
    parameter  int WIDTH = WORD_W,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_dat
);

    // Contents are never reset; the queue masks empty slots at its output
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Single write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem_q[rd_addr];

endmodule

// File: rtl/ingress_queue.sv
// Show-ahead ingress queue in front of the scheduler; zero words are dropped and counted.
// Latency: a word written into an empty queue appears on data one cycle later.
// Backpressure: in_ready = !full, and a same-cycle pop does not free a slot.
module ingress_queue
    import switch_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] data,
    output logic [1:0]       usedw,
    input  logic             rdreq,
    output logic             full,
    output logic [7:0]       drop_cnt,
    output logic             underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic [WIDTH-1:0] data_q,   data_d;
    logic [1:0]       usedw_q,  usedw_d;
    logic             full_q,   full_d;
    logic [7:0]       drop_q,   drop_d;
    logic             unf_q,    unf_d;

    logic             wr_en;
    logic             rd_en;
    logic             drop_en;
    logic [WIDTH-1:0] ram_rd_dat;

    // Read address is the next head so the registered data output is ready one cycle after the update
    queue_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_dat  (in_data),
        .rd_addr (rd_ptr_d),
        .rd_dat  (ram_rd_dat)
    );

    // Ready comes straight from the registered full flag: no pop-to-write bypass
    assign in_ready = !full_q;

    // Next-state: handshakes, pointers, occupancy and the registered output values
    always_comb begin
        wr_en    = in_valid && in_ready && (in_data != '0);
        drop_en  = in_valid && in_ready && (in_data == '0);
        rd_en    = rdreq && (count_q != '0);

        count_d  = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;

        drop_d   = (drop_en && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
        unf_d    = rdreq && (count_q == '0);
        full_d   = (count_d == CW'(DEPTH));
        usedw_d  = (count_d > CW'(3)) ? 2'd3 : count_d[1:0];

        // The next head is the word being written only when the queue drains to that slot this cycle
        if (count_d == '0) begin
            data_d = '0;
        end else if (wr_en && (rd_ptr_d == wr_ptr_q)) begin
            data_d = in_data;
        end else begin
            data_d = ram_rd_dat;
        end
    end

    // State and registered outputs, all cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= '0;
            usedw_q  <= '0;
            full_q   <= 1'b0;
            drop_q   <= '0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            data_q   <= data_d;
            usedw_q  <= usedw_d;
            full_q   <= full_d;
            drop_q   <= drop_d;
            unf_q    <= unf_d;
        end
    end

    assign data      = data_q;
    assign usedw     = usedw_q;
    assign full      = full_q;
    assign drop_cnt  = drop_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_ingress_queue.sv
// Bench for ingress_queue: directed stimulus, scoreboard of expected pop words.
// A negedge monitor checks every rdreq cycle against the scoreboard.
// Status outputs are checked directly just after each clock edge.
module tb_ingress_queue;

    localparam int W = 32;
    localparam int D = 4;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] data;
    logic [1:0]   usedw;
    logic         rdreq;
    logic         full;
    logic [7:0]   drop_cnt;
    logic         underflow;

    int           n_chk  = 0;
    int           n_pass = 0;
    int           m_cnt  = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_w;

    ingress_queue #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data      (data),
        .usedw     (usedw),
        .rdreq     (rdreq),
        .full      (full),
        .drop_cnt  (drop_cnt),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the expected word is queued when the write will be accepted
    task automatic cyc(input logic v, input logic [31:0] d, input logic r);
        bit acc;
        bit pop;
        in_valid = v;
        in_data  = d;
        rdreq    = r;
        acc = v && (d != 32'h0) && (m_cnt != D);
        pop = r && (m_cnt != 0);
        if (acc) exp_q.push_back(d);
        m_cnt = m_cnt + int'(acc) - int'(pop);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = '0;
        rdreq    = 1'b0;
    endtask

    // Monitor: each rdreq cycle either pops the scoreboard or must show idle data
    always @(negedge clk) begin
        if (!reset && rdreq) begin
            if (usedw != 2'd0) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL pop_unexpected: got data 0x%0h, expected no word available", data);
                end else begin
                    exp_w = exp_q.pop_front();
                    chk("pop_data", data, exp_w);
                end
            end else begin
                chk("idle_data", data, 32'h0);
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int bad_rdy;
        in_valid = 1'b0;
        in_data  = '0;
        rdreq    = 1'b0;

        // Reset state
        #3;
        chk("rst_data",  data,      32'h0);
        chk("rst_usedw", usedw,     32'h0);
        chk("rst_full",  full,      32'h0);
        chk("rst_ready", in_ready,  32'h1);
        chk("rst_drop",  drop_cnt,  32'h0);
        chk("rst_unf",   underflow, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single word: latency 1, then pop to idle
        cyc(1'b1, 32'h0000_0005, 1'b0);
        chk("w5_data",  data,  32'h5);
        chk("w5_usedw", usedw, 32'h1);
        cyc(1'b0, 32'h0, 1'b1);
        chk("p5_data",  data,  32'h0);
        chk("p5_usedw", usedw, 32'h0);

        // Fill to full, rejected write, drain in order
        cyc(1'b1, 32'hA1, 1'b0);
        cyc(1'b1, 32'hA2, 1'b0);
        cyc(1'b1, 32'hA3, 1'b0);
        cyc(1'b1, 32'hA4, 1'b0);
        chk("fill_full",  full,     32'h1);
        chk("fill_ready", in_ready, 32'h0);
        chk("fill_usedw", usedw,    32'h3);
        cyc(1'b1, 32'hA5, 1'b0);
        chk("a5_full",  full,  32'h1);
        chk("a5_usedw", usedw, 32'h3);
        chk("a5_head",  data,  32'hA1);
        cyc(1'b0, 32'h0, 1'b1);
        chk("drain1_full", full, 32'h0);
        cyc(1'b0, 32'h0, 1'b1);
        cyc(1'b0, 32'h0, 1'b1);
        cyc(1'b0, 32'h0, 1'b1);
        chk("drain_usedw", usedw, 32'h0);
        chk("drain_data",  data,  32'h0);

        // Steady push+pop with 2 entries across pointer wrap
        cyc(1'b1, 32'hB0, 1'b0);
        cyc(1'b1, 32'hB1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 32'hC0 + i, 1'b1);
            chk("pp_usedw", usedw, 32'h2);
        end
        cyc(1'b0, 32'h0, 1'b1);
        cyc(1'b0, 32'h0, 1'b1);
        chk("pp_end_usedw", usedw, 32'h0);

        // Zero words are dropped; counter saturates
        bad_rdy = 0;
        for (int i = 0; i < 300; i++) begin
            if (in_ready !== 1'b1) bad_rdy++;
            cyc(1'b1, 32'h0, 1'b0);
            if (i == 99) chk("drop_100", drop_cnt, 32'd100);
        end
        chk("drop_sat",   drop_cnt, 32'd255);
        chk("drop_usedw", usedw,    32'h0);
        chk("drop_ready", bad_rdy,  32'h0);

        // Underflow pulse, pointers untouched
        cyc(1'b0, 32'h0, 1'b1);
        chk("unf_pulse", underflow, 32'h1);
        chk("unf_usedw", usedw,     32'h0);
        cyc(1'b0, 32'h0, 1'b0);
        chk("unf_clear", underflow, 32'h0);
        cyc(1'b1, 32'hD1, 1'b0);
        chk("d1_head", data, 32'hD1);
        cyc(1'b0, 32'h0, 1'b1);

        // Write on empty with rdreq: write applies and underflow fires
        cyc(1'b1, 32'hE1, 1'b1);
        chk("e1_unf",   underflow, 32'h1);
        chk("e1_usedw", usedw,     32'h1);
        chk("e1_data",  data,      32'hE1);
        cyc(1'b1, 32'hE2, 1'b0);
        cyc(1'b1, 32'hE3, 1'b0);
        cyc(1'b1, 32'hE4, 1'b0);
        chk("e_full", full, 32'h1);
        // Full with write and pop together: pop only
        cyc(1'b1, 32'hE5, 1'b1);
        chk("fp_usedw", usedw, 32'h3);
        chk("fp_full",  full,  32'h0);
        chk("fp_head",  data,  32'hE2);
        cyc(1'b0, 32'h0, 1'b1);
        cyc(1'b0, 32'h0, 1'b1);
        cyc(1'b0, 32'h0, 1'b1);
        chk("e_drain_usedw", usedw, 32'h0);

        // Asynchronous reset mid-burst with 3 entries
        cyc(1'b1, 32'hF1, 1'b0);
        cyc(1'b1, 32'hF2, 1'b0);
        cyc(1'b1, 32'hF3, 1'b0);
        chk("f_usedw", usedw, 32'h3);
        in_valid = 1'b1;
        in_data  = 32'hF4;
        rdreq    = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("arst_usedw", usedw,    32'h0);
        chk("arst_data",  data,     32'h0);
        chk("arst_drop",  drop_cnt, 32'h0);
        chk("arst_full",  full,     32'h0);
        chk("arst_ready", in_ready, 32'h1);
        exp_q.delete();
        m_cnt    = 0;
        in_valid = 1'b0;
        in_data  = '0;
        rdreq    = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc(1'b1, 32'h61, 1'b0);
        chk("post_rst_data",  data,  32'h61);
        chk("post_rst_usedw", usedw, 32'h1);
        cyc(1'b0, 32'h0, 1'b1);
        chk("post_rst_empty", usedw, 32'h0);

        chk("sb_empty", exp_q.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ingress_queue.md
INGRESS_QUEUE -- requirements
Module: ingress_queue

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the packet word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the number of queue entries; DEPTH is a power of two and at least 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port in_data, input, WIDTH bits: the arriving packet word; bits [1:0] hold the destination port code.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_data is valid this cycle.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the queue accepts a word this cycle.
REQ-008 The block SHALL have port data, output, WIDTH bits: the head-of-queue word, show-ahead, consumed by the scheduler.
REQ-009 The block SHALL have port usedw, output, 2 bits: the occupancy, saturated at 3, where non-zero means the head is valid.
REQ-010 The block SHALL have port rdreq, input, 1 bit: pop the head word at the end of this cycle.
REQ-011 The block SHALL have port full, output, 1 bit: the occupancy equals DEPTH.
REQ-012 The block SHALL have port drop_cnt, output, 8 bits: a saturating count of zero words discarded at ingress.
REQ-013 The block SHALL have port underflow, output, 1 bit: a one-cycle pulse when rdreq arrives while the queue is empty.

Function
REQ-014 The block SHALL drive in_ready = !full combinationally, with no bypass: a pop in the same cycle does not free a slot for a write in that cycle.
REQ-015 The block SHALL complete a write when in_valid && in_ready && in_data != 0; the word enters at the tail.
REQ-016 The block SHALL discard a word when in_valid && in_ready && in_data == 0, because all-zero is the idle code; drop_cnt increments by 1 and stops at 255.
REQ-017 The block SHALL complete a pop when rdreq && count != 0; the head advances.
REQ-018 The block SHALL complete a write and a pop together in one cycle when both occur with count != 0; count is then unchanged.
REQ-019 The block SHALL apply a write when count == 0 with a simultaneous rdreq, and the rdreq is then the underflow case of REQ-023.
REQ-020 The block SHALL show a written word on data one cycle after the write edge when the queue was empty (latency 1); there is no same-cycle fall-through.
REQ-021 The block SHALL drive data = 0 whenever count == 0, so the scheduler sees idle.
REQ-022 The block SHALL keep an internal count of width clog2(DEPTH)+1 and drive usedw = min(count, 3); full = (count == DEPTH).
REQ-023 The block SHALL assert underflow for one cycle when rdreq && count == 0; state is unchanged.
REQ-024 The block SHALL use read and write pointers of width clog2(DEPTH) that wrap modulo DEPTH with no gap in the sequence.
REQ-025 The block SHALL register all outputs except in_ready.

Reset
REQ-026 On assertion of reset, asynchronously, the block SHALL set count, both pointers, drop_cnt and underflow to 0; data reads 0, usedw = 0, full = 0 and in_ready = 1.
REQ-027 The block SHALL NOT reset storage contents; they are unobservable because data is forced to 0 when the queue is empty.
REQ-028 On reset during a write or pop, the block SHALL lose the operation, and the first post-reset write SHALL occupy entry 0.

Structure
REQ-029 The block SHALL take WORD_W = 32 and the port codes (PORT1 = 2'b01, PORT2 = 2'b10, PORT3 = 2'b11, IDLE = 2'b00) from the shared package switch_pkg, which ingress_queue and the scheduler both import.
REQ-030 The block SHALL place its storage in one sub-module, queue_ram (DEPTH x WIDTH, one write port, combinational read); pointer, count and handshake control stay in ingress_queue.

Verification
REQ-031 The bench SHALL cover: after reset, write 0x0000_0005 -> next cycle data = 0x0000_0005, usedw = 1; rdreq for one cycle -> data = 0, usedw = 0.
REQ-032 The bench SHALL cover: write 0xA1, 0xA2, 0xA3, 0xA4 -> full = 1, in_ready = 0, usedw = 3; in_valid with 0xA5 while full -> not stored; 4 pops return A1..A4 in order.
REQ-033 The bench SHALL cover: with 2 entries, in_valid and rdreq together for 10 cycles -> usedw stays 2 and the order is preserved across pointer wrap.
REQ-034 The bench SHALL cover: 300 writes of 0x0 -> drop_cnt = 255, usedw = 0, in_ready = 1 throughout.
REQ-035 The bench SHALL cover: rdreq on an empty queue -> underflow = 1 for exactly one cycle, pointers unchanged; full with rdreq and in_valid together -> pop only, usedw = 3, full = 0 next cycle.
REQ-036 The bench SHALL cover: assert reset mid-burst with 3 entries -> usedw = 0, data = 0, drop_cnt = 0 immediately, without waiting for a clock edge.
